// File: rtl/chan_gate_mux_rr.sv
// chan_gate_mux_rr: N-channel gated mux with a registered valid/ready output.
// The channel comes from sel_in (MODE=0) or from round-robin arbitration
// (MODE=1). out_data reads as zero whenever out_valid is low.
module chan_gate_mux_rr #(
  parameter  int unsigned WIDTH  = 16,
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned MODE   = 0,
  localparam int unsigned CHW    = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [CHW-1:0]          sel_in,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CHW-1:0]          out_ch
);

  logic [WIDTH-1:0]  r_data;
  logic              r_valid;
  logic [CHW-1:0]    r_ch;
  logic [CHW-1:0]    r_rr_ptr;

  logic [NUM_CH-1:0] w_grant;
  logic              w_found;
  int unsigned       w_idx;
  logic              w_can_load;
  logic              w_xfer;
  logic [CHW-1:0]    w_sel_idx;
  logic [WIDTH-1:0]  w_sel_data;

  // Grant: fixed select or round-robin scan starting just after the last winner
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    if (MODE == 0) begin
      if (32'(sel_in) < NUM_CH) begin
        w_grant[sel_in] = in_valid[sel_in];
      end
    end else begin
      for (int unsigned k = 1; k <= NUM_CH; k++) begin
        w_idx = (32'(r_rr_ptr) + k) % NUM_CH;
        if (!w_found && in_valid[CHW'(w_idx)]) begin
          w_grant[CHW'(w_idx)] = 1'b1;
          w_found              = 1'b1;
        end
      end
    end
  end

  // Handshake and selected word; the grant never looks at any ready signal
  always_comb begin
    w_can_load = ~r_valid | out_ready;
    in_ready   = w_grant & {NUM_CH{w_can_load}};
    w_xfer     = |(in_ready & in_valid);
    w_sel_idx  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_grant[i]) begin
        w_sel_idx = CHW'(i);
      end
    end
    w_sel_data = in_data[w_sel_idx*WIDTH +: WIDTH];
  end

  // Output register: load on transfer, zero-gate on drain, hold on stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_ch     <= '0;
      r_rr_ptr <= CHW'(NUM_CH - 1);
    end else if (w_xfer) begin
      r_data  <= w_sel_data;
      r_ch    <= w_sel_idx;
      r_valid <= 1'b1;
      if (MODE == 1) begin
        r_rr_ptr <= w_sel_idx;
      end
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_ch    = r_ch;

endmodule

// File: tb/tb_chan_gate_mux_rr.sv
// Bench for chan_gate_mux_rr: three instances share one stimulus
// (4-ch fixed select, 4-ch round-robin, 3-ch fixed select) and are checked
// each cycle against a queue-free behavioural model plus literal expectations.
module tb_chan_gate_mux_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [1:0]  sel;
  logic        out_ready;

  logic [3:0]  rdy0, rdy1;
  logic [2:0]  rdy2;
  logic [15:0] od0, od1, od2;
  logic        ov0, ov1, ov2;
  logic [1:0]  och0, och1, och2;

  int n_tests = 0;
  int n_fail  = 0;

  chan_gate_mux_rr #(.WIDTH(16), .NUM_CH(4), .MODE(0)) u_fix4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .sel_in(sel), .out_data(od0), .out_valid(ov0),
    .out_ready(out_ready), .out_ch(och0));

  chan_gate_mux_rr #(.WIDTH(16), .NUM_CH(4), .MODE(1)) u_rr4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .sel_in(sel), .out_data(od1), .out_valid(ov1),
    .out_ready(out_ready), .out_ch(och1));

  chan_gate_mux_rr #(.WIDTH(16), .NUM_CH(3), .MODE(0)) u_fix3 (
    .clk(clk), .rst(rst), .in_data(in_data[47:0]), .in_valid(in_valid[2:0]),
    .in_ready(rdy2), .sel_in(sel), .out_data(od2), .out_valid(ov2),
    .out_ready(out_ready), .out_ch(och2));

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t got=%0h want=%0h", name, inst, $time, act, exp);
    end
  endtask

  // Actual outputs gathered per instance for the model compare
  logic [15:0] a_data [3];
  logic        a_valid[3];
  logic [1:0]  a_ch   [3];
  logic [3:0]  a_rdy  [3];
  assign a_data[0] = od0;  assign a_data[1] = od1;  assign a_data[2] = od2;
  assign a_valid[0] = ov0; assign a_valid[1] = ov1; assign a_valid[2] = ov2;
  assign a_ch[0] = och0;   assign a_ch[1] = och1;   assign a_ch[2] = och2;
  assign a_rdy[0] = rdy0;  assign a_rdy[1] = rdy1;  assign a_rdy[2] = {1'b0, rdy2};

  // Model state per instance
  int          nch [3] = '{4, 4, 3};
  int          mode[3] = '{0, 1, 0};
  bit          m_valid[3];
  logic [15:0] m_data [3];
  int          m_ch   [3];
  int          m_ptr  [3];
  bit          n_valid[3];
  logic [15:0] n_data [3];
  int          n_ch   [3];
  int          n_ptr  [3];

  // Compare process: evaluate model at the falling edge, commit at the rising edge
  always begin
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      int   g;
      bit   can;
      logic [3:0] exp_rdy;
      if (rst) begin
        m_valid[k] = 1'b0; m_data[k] = '0; m_ch[k] = 0; m_ptr[k] = nch[k] - 1;
      end
      g   = -1;
      can = !m_valid[k] || out_ready;
      if (mode[k] == 0) begin
        if (int'(sel) < nch[k] && in_valid[sel]) g = int'(sel);
      end else begin
        for (int off = 1; off <= nch[k]; off++) begin
          int c;
          c = (m_ptr[k] + off) % nch[k];
          if (g < 0 && in_valid[c]) g = c;
        end
      end
      exp_rdy = (g >= 0 && can) ? 4'(1 << g) : 4'b0;
      check("out_valid", k, 32'(a_valid[k]), 32'(m_valid[k]));
      check("out_data",  k, 32'(a_data[k]),  32'(m_data[k]));
      check("out_ch",    k, 32'(a_ch[k]),    32'(m_ch[k]));
      check("in_ready",  k, 32'(a_rdy[k]),   32'(exp_rdy));
      n_valid[k] = m_valid[k]; n_data[k] = m_data[k];
      n_ch[k]    = m_ch[k];    n_ptr[k]  = m_ptr[k];
      if (g >= 0 && can) begin
        n_valid[k] = 1'b1;
        n_data[k]  = in_data[g*16 +: 16];
        n_ch[k]    = g;
        if (mode[k] == 1) n_ptr[k] = g;
      end else if (m_valid[k] && out_ready) begin
        n_valid[k] = 1'b0;
        n_data[k]  = '0;
      end
    end
    @(posedge clk);
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        m_valid[k] = n_valid[k]; m_data[k] = n_data[k];
        m_ch[k]    = n_ch[k];    m_ptr[k]  = n_ptr[k];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_ch(input int c, input logic [15:0] v);
    in_data[c*16 +: 16] = v;
  endtask

  // Directed vectors: {in_valid, sel, out_ready}
  logic [6:0] vec[10] = '{7'b1010_01_1, 7'b0110_10_0, 7'b0110_10_1, 7'b1111_11_1,
                          7'b0001_00_0, 7'b0001_00_0, 7'b1001_11_1, 7'b0000_01_1,
                          7'b0100_10_1, 7'b1110_00_1};
  int exp_rr[6] = '{0, 1, 2, 3, 0, 1};
  int exp_alt[5] = '{1, 3, 1, 3, 1};

  initial begin
    rst = 1'b1; in_data = '0; in_valid = '0; sel = '0; out_ready = 1'b0;
    for (int c = 0; c < 4; c++) set_ch(c, 16'(16'hA000 + c));
    #2;
    do_reset();
    check("reset_valid", 0, 32'(ov0), 32'd0);
    check("reset_ptr_first", 1, 32'(och1), 32'd0);

    // Round-robin with all channels valid: 0,1,2,3,0,1 back to back
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_seq_ch", 1, 32'(och1), 32'(exp_rr[i]));
      check("rr_seq_data", 1, 32'(od1), 32'(16'hA000 + exp_rr[i]));
      check("rr_seq_valid", 1, 32'(ov1), 32'd1);
    end

    // Only ch1 and ch3 valid: 1,3,1,3,1 after reset
    in_valid = 4'b0000;
    do_reset();
    in_valid = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_alt_ch", 1, 32'(och1), 32'(exp_alt[i]));
    end

    // Fixed select of channel 2
    sel = 2'd2; in_valid = 4'b0100; set_ch(2, 16'h1234);
    #1;
    check("sel2_ready", 0, 32'(rdy0), 32'b0100);
    step();
    check("sel2_data", 0, 32'(od0), 32'h1234);
    check("sel2_ch", 0, 32'(och0), 32'd2);

    // Backpressure: hold for 5 cycles, then drain and reload with no bubble
    in_valid = 4'b0000;
    do_reset();
    sel = 2'd0; in_valid = 4'b0001; set_ch(0, 16'h00AA); out_ready = 1'b0;
    step();
    set_ch(0, 16'h00BB);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_data", 0, 32'(od0), 32'h00AA);
      check("stall_ready", 0, 32'(rdy0), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("reload_ready", 0, 32'(rdy0), 32'b0001);
    step();
    check("reload_data", 0, 32'(od0), 32'h00BB);
    check("reload_valid", 0, 32'(ov0), 32'd1);

    // Idle gating: drain with nothing valid
    in_valid = 4'b0000;
    step();
    check("idle_valid", 0, 32'(ov0), 32'd0);
    check("idle_data", 0, 32'(od0), 32'd0);

    // Select beyond the 3-channel range never grants
    sel = 2'd3; in_valid = 4'b1111;
    #1;
    check("oor_ready", 2, 32'(rdy2), 32'd0);
    step();
    check("oor_valid", 2, 32'(ov2), 32'd0);

    // Directed mixed vectors
    for (int i = 0; i < 10; i++) begin
      in_valid  = vec[i][6:3];
      sel       = vec[i][2:1];
      out_ready = vec[i][0];
      for (int c = 0; c < 4; c++) set_ch(c, 16'(16'h1000 * (i + 1) + c));
      step();
    end

    // Asynchronous reset while a word is held
    sel = 2'd1; in_valid = 4'b0010; set_ch(1, 16'h5A5A); out_ready = 1'b0;
    step();
    check("pre_rst_valid", 0, 32'(ov0), 32'd1);
    rst = 1'b1;
    #1;
    check("async_valid", 0, 32'(ov0), 32'd0);
    check("async_data", 0, 32'(od0), 32'd0);
    check("async_ch", 0, 32'(och0), 32'd0);
    step();
    rst = 1'b0;
    in_valid = 4'b0000;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
